// File: rtl/clock_alarm_if.sv
// clock_alarm_if: button pulses (mode, sel, adj) toward the clock; BCD digits, PM, blink enables, alarm status and mode out
interface clock_alarm_if;
  logic       mode, sel, adj;
  logic [1:0] h10;
  logic [3:0] h1;
  logic [2:0] m10;
  logic [3:0] m1;
  logic [2:0] s10;
  logic [3:0] s1;
  logic       pm, hon, mon, son, alm_en, alarm;
  logic [1:0] mode_st;
  modport master (output mode, sel, adj,
                  input h10, h1, m10, m1, s10, s1, pm, hon, mon, son, alm_en, alarm, mode_st);
  modport slave  (input mode, sel, adj,
                  output h10, h1, m10, m1, s10, s1, pm, hon, mon, son, alm_en, alarm, mode_st);
endinterface

// File: rtl/clock_alarm.sv
// clock_alarm: settable 12/24h clock with alarm; clk, async active-low rst_n, bus carries buttons in and display/status out
module clock_alarm #(
  parameter int CLK_HZ   = 50000000,
  parameter bit H24      = 1'b1,
  parameter int ALM_SECS = 60
) (
  input logic        clk,
  input logic        rst_n,
  clock_alarm_if.slave bus
);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [4:0] H0 = H24 ? 5'd0 : 5'd12;
  typedef enum logic [1:0] {NORM, TSET, ASET} mode_t;
  typedef enum logic [1:0] {HOUR, MIN, SEC} fld_t;
  mode_t mode_q, mode_d;
  fld_t fld_q, fld_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0] h_q, h_d, ah_q, ah_d;
  logic [5:0] m_q, m_d, s_q, s_d, am_q, am_d;
  logic pm_q, pm_d, apm_q, apm_d, alm_en_q, alm_en_d, alarm_q, alarm_d, adv_q, adv_d;
  logic [7:0] ring_q, ring_d;
  logic tick, blink, run, btn;
  function automatic logic [5:0] hr_inc(input logic [4:0] h, input logic p);
    return H24 ? {1'b0, (h == 5'd23 ? 5'd0 : h + 5'd1)}
               : {p ^ (h == 5'd11), (h == 5'd12 ? 5'd1 : h + 5'd1)};
  endfunction
  function automatic logic [5:0] mn_inc(input logic [5:0] v);
    return v == 6'd59 ? 6'd0 : v + 6'd1;
  endfunction
  function automatic logic [6:0] bcd(input logic [5:0] v);
    return {3'(v / 6'd10), 4'(v % 6'd10)};
  endfunction
  always_comb begin
    tick     = presc_q == PW'(CLK_HZ - 1);
    blink    = presc_q < PW'(CLK_HZ / 2);
    run      = tick && mode_q != TSET;
    btn      = bus.mode | bus.sel | bus.adj;
    presc_d  = tick ? '0 : presc_q + 1'b1;
    mode_d   = mode_q;
    fld_d    = fld_q;
    h_d      = h_q;
    m_d      = m_q;
    s_d      = s_q;
    pm_d     = pm_q;
    ah_d     = ah_q;
    am_d     = am_q;
    apm_d    = apm_q;
    alm_en_d = alm_en_q;
    alarm_d  = alarm_q;
    ring_d   = ring_q;
    adv_d    = run;
    if (run) begin
      s_d = mn_inc(s_q);
      if (s_q == 6'd59) m_d = mn_inc(m_q);
      if (s_q == 6'd59 && m_q == 6'd59) {pm_d, h_d} = hr_inc(h_q, pm_q);
    end
    if (alarm_q && tick) begin
      alarm_d = ring_q != 8'(ALM_SECS - 1);
      ring_d  = ring_q == 8'(ALM_SECS - 1) ? '0 : ring_q + 8'd1;
    end
    // adv_q marks a tick-driven update, so manual edits that land on the alarm never ring
    if (!alarm_q && alm_en_q && adv_q && h_q == ah_q && m_q == am_q && s_q == 6'd0 && pm_q == apm_q)
      alarm_d = 1'b1;
    // any button while ringing only silences the alarm
    if (alarm_q && btn) begin
      alarm_d = 1'b0;
      ring_d  = '0;
    end else if (bus.mode) begin
      mode_d = mode_q == NORM ? TSET : mode_q == TSET ? ASET : NORM;
      fld_d  = HOUR;
    end else if (bus.sel && mode_q != NORM) begin
      fld_d = fld_q == HOUR ? MIN : (fld_q == MIN && mode_q == TSET) ? SEC : HOUR;
    end else if (bus.adj) begin
      if (mode_q == NORM) alm_en_d = !alm_en_q;
      else if (mode_q == TSET) begin
        if (fld_q == HOUR) {pm_d, h_d} = hr_inc(h_q, pm_q);
        else if (fld_q == MIN) m_d = mn_inc(m_q);
        else begin
          s_d     = '0;
          presc_d = '0;
        end
      end else if (fld_q == HOUR) {apm_d, ah_d} = hr_inc(ah_q, apm_q);
      else am_d = mn_inc(am_q);
    end
    alarm_d = alarm_d && alm_en_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc_q  <= '0;
      mode_q   <= NORM;
      fld_q    <= HOUR;
      h_q      <= H0;
      m_q      <= '0;
      s_q      <= '0;
      pm_q     <= 1'b0;
      ah_q     <= H0;
      am_q     <= '0;
      apm_q    <= 1'b0;
      alm_en_q <= 1'b0;
      alarm_q  <= 1'b0;
      ring_q   <= '0;
      adv_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      fld_q    <= fld_d;
      h_q      <= h_d;
      m_q      <= m_d;
      s_q      <= s_d;
      pm_q     <= pm_d;
      ah_q     <= ah_d;
      am_q     <= am_d;
      apm_q    <= apm_d;
      alm_en_q <= alm_en_d;
      alarm_q  <= alarm_d;
      ring_q   <= ring_d;
      adv_q    <= adv_d;
    end
  assign {bus.h10, bus.h1} = 6'(bcd({1'b0, (mode_q == ASET ? ah_q : h_q)}));
  assign {bus.m10, bus.m1} = bcd(mode_q == ASET ? am_q : m_q);
  assign {bus.s10, bus.s1} = bcd(mode_q == ASET ? 6'd0 : s_q);
  assign bus.pm      = !H24 && (mode_q == ASET ? apm_q : pm_q);
  assign bus.hon     = mode_q == NORM || fld_q != HOUR || blink;
  assign bus.mon     = mode_q == NORM || fld_q != MIN || blink;
  assign bus.son     = mode_q == NORM || (mode_q == TSET && (fld_q != SEC || blink));
  assign bus.alm_en  = alm_en_q;
  assign bus.alarm   = alarm_q;
  assign bus.mode_st = mode_q;
endmodule

// File: tb/tb_clock_alarm.sv
// tb_clock_alarm: directed vector table plus hand sequences for wrap, PM, alarm ring/stop and reset on 24h and 12h instances
module tb_clock_alarm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cur = 0;
  int n_pass = 0;
  int n_tot = 0;
  clock_alarm_if a_if ();
  clock_alarm_if b_if ();
  clock_alarm #(.CLK_HZ(4), .H24(1'b1), .ALM_SECS(3)) u24 (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  clock_alarm #(.CLK_HZ(4), .H24(1'b0), .ALM_SECS(3)) u12 (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  always #5 clk = ~clk;
  typedef struct {
    bit m, s, a;
    int n, h, mi, se, md, en;
  } vec_t;
  vec_t tv[11];
  int mexp[5];
  function automatic int tm(input int h, input int m, input int s);
    return int'({2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)});
  endfunction
  function automatic int dsp();
    return cur != 0 ? int'({b_if.h10, b_if.h1, b_if.m10, b_if.m1, b_if.s10, b_if.s1})
                    : int'({a_if.h10, a_if.h1, a_if.m10, a_if.m1, a_if.s10, a_if.s1});
  endfunction
  function automatic int g_md();
    return cur != 0 ? int'(b_if.mode_st) : int'(a_if.mode_st);
  endfunction
  function automatic int g_al();
    return cur != 0 ? int'(b_if.alarm) : int'(a_if.alarm);
  endfunction
  function automatic int g_ae();
    return cur != 0 ? int'(b_if.alm_en) : int'(a_if.alm_en);
  endfunction
  function automatic int g_pm();
    return cur != 0 ? int'(b_if.pm) : int'(a_if.pm);
  endfunction
  function automatic int g_en3();
    return cur != 0 ? int'({b_if.hon, b_if.mon, b_if.son}) : int'({a_if.hon, a_if.mon, a_if.son});
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask
  task automatic press(input bit m, input bit s, input bit a, input int n);
    for (int i = 0; i < n; i++) begin
      if (cur == 0) begin
        a_if.mode = m; a_if.sel = s; a_if.adj = a;
      end else begin
        b_if.mode = m; b_if.sel = s; b_if.adj = a;
      end
      @(negedge clk);
      a_if.mode = 0; a_if.sel = 0; a_if.adj = 0;
      b_if.mode = 0; b_if.sel = 0; b_if.adj = 0;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    a_if.mode = 0; a_if.sel = 0; a_if.adj = 0;
    b_if.mode = 0; b_if.sel = 0; b_if.adj = 0;
    tv[0]  = '{1'b1, 1'b1, 1'b1, 1, 0, 0, 0, 1, 0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 24, 0, 0, 0, 1, 0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 23, 23, 0, 0, 1, 0};
    tv[3]  = '{1'b0, 1'b1, 1'b0, 1, 23, 0, 0, 1, 0};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 59, 23, 59, 0, 1, 0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1, 23, 0, 0, 1, 0};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 59, 23, 59, 0, 1, 0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 1, 23, 59, 0, 1, 0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1, 23, 59, 0, 1, 0};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 2, 0};
    tv[10] = '{1'b1, 1'b0, 1'b0, 1, 23, 59, 0, 0, 0};
    mexp = '{0, 0, 1, 1, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset time", dsp(), tm(0, 0, 0));
    chk("reset mode", g_md(), 0);
    chk("reset alarm", g_al(), 0);
    chk("reset alm_en", g_ae(), 0);
    chk("reset pm", g_pm(), 0);
    chk("reset enables", g_en3(), 7);
    for (int i = 0; i < 11; i++) begin
      press(tv[i].m, tv[i].s, tv[i].a, tv[i].n);
      chk($sformatf("vec%0d time", i), dsp(), tm(tv[i].h, tv[i].mi, tv[i].se));
      chk($sformatf("vec%0d mode", i), g_md(), tv[i].md);
      chk($sformatf("vec%0d alm_en", i), g_ae(), tv[i].en);
    end
    idle(230);
    chk("24h 23:59:58", dsp(), tm(23, 59, 58));
    idle(4);
    chk("24h 23:59:59", dsp(), tm(23, 59, 59));
    idle(3);
    chk("24h hold before tick", dsp(), tm(23, 59, 59));
    idle(1);
    chk("24h wrap 00:00:00", dsp(), tm(0, 0, 0));
    chk("24h pm", g_pm(), 0);
    chk("norm enables", g_en3(), 7);
    press(1, 0, 0, 1);
    press(0, 1, 0, 2);
    press(0, 0, 1, 1);
    press(0, 1, 0, 2);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("tset min blink %0d", i), g_en3(), mexp[i] != 0 ? 7 : 5);
      idle(1);
    end
    chk("tset holds time", dsp(), tm(0, 0, 0));
    press(0, 1, 0, 2);
    press(0, 0, 1, 7);
    press(0, 1, 0, 1);
    press(0, 0, 1, 29);
    press(0, 1, 0, 1);
    press(0, 0, 1, 1);
    chk("time preset", dsp(), tm(7, 29, 0));
    press(1, 0, 0, 1);
    chk("aset son", g_en3() & 1, 0);
    press(0, 0, 1, 7);
    press(0, 1, 0, 1);
    press(0, 0, 1, 30);
    chk("alarm shown", dsp(), tm(7, 30, 0));
    chk("aset mode", g_md(), 2);
    press(1, 0, 0, 1);
    press(0, 0, 1, 1);
    chk("arm", g_ae(), 1);
    chk("back to norm", g_md(), 0);
    idle(199);
    chk("reach 07:30:00", dsp(), tm(7, 30, 0));
    chk("alarm not yet", g_al(), 0);
    idle(1);
    chk("alarm rises", g_al(), 1);
    idle(10);
    chk("alarm still ringing", g_al(), 1);
    idle(1);
    chk("alarm stops after 3 ticks", g_al(), 0);
    chk("alm_en after ring", g_ae(), 1);
    press(1, 0, 0, 1);
    press(0, 1, 0, 2);
    press(0, 0, 1, 1);
    idle(2);
    chk("tset match time", dsp(), tm(7, 30, 0));
    chk("tset match no ring", g_al(), 0);
    press(0, 1, 0, 2);
    press(0, 0, 1, 59);
    press(0, 1, 0, 1);
    press(0, 0, 1, 1);
    press(1, 0, 0, 2);
    idle(239);
    chk("second ring", g_al(), 1);
    press(0, 1, 0, 1);
    chk("sel stops ring", g_al(), 0);
    chk("sel consumed mode", g_md(), 0);
    chk("sel keeps alm_en", g_ae(), 1);
    press(1, 0, 0, 1);
    press(0, 1, 0, 1);
    press(0, 0, 1, 59);
    press(0, 1, 0, 1);
    press(0, 0, 1, 1);
    press(1, 0, 0, 1);
    idle(240);
    chk("ring in aset", g_al(), 1);
    chk("ring mode aset", g_md(), 2);
    rst_n = 1'b0;
    #1;
    chk("async reset time", dsp(), tm(0, 0, 0));
    chk("async reset mode", g_md(), 0);
    chk("async reset alarm", g_al(), 0);
    chk("async reset alm_en", g_ae(), 0);
    chk("async reset enables", g_en3(), 7);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("no early tick", dsp(), tm(0, 0, 0));
    idle(1);
    chk("first tick after reset", dsp(), tm(0, 0, 1));
    cur = 1;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("12h reset time", dsp(), tm(12, 0, 0));
    chk("12h reset pm", g_pm(), 0);
    press(1, 0, 0, 1);
    press(0, 0, 1, 11);
    chk("12h 11 am", dsp(), tm(11, 0, 0));
    chk("12h 11 am pm", g_pm(), 0);
    press(0, 1, 0, 1);
    press(0, 0, 1, 59);
    press(0, 1, 0, 1);
    press(0, 0, 1, 1);
    press(1, 0, 0, 2);
    idle(234);
    chk("12h 11:59:59", dsp(), tm(11, 59, 59));
    chk("12h 11:59:59 am", g_pm(), 0);
    idle(4);
    chk("12h noon", dsp(), tm(12, 0, 0));
    chk("12h noon pm", g_pm(), 1);
    press(1, 0, 0, 1);
    press(0, 1, 0, 1);
    press(0, 0, 1, 59);
    press(0, 1, 0, 1);
    press(0, 0, 1, 1);
    press(1, 0, 0, 2);
    idle(234);
    chk("12h 12:59:59", dsp(), tm(12, 59, 59));
    idle(4);
    chk("12h 01:00:00", dsp(), tm(1, 0, 0));
    chk("12h 01 pm", g_pm(), 1);
    press(1, 0, 0, 1);
    press(0, 0, 1, 10);
    chk("12h adj 11 pm", dsp(), tm(11, 0, 0));
    press(0, 0, 1, 1);
    chk("12h adj midnight", dsp(), tm(12, 0, 0));
    chk("12h adj midnight am", g_pm(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
